int_controller: RTL and testbench
=================================

INT_CONTROLLER -- requirements
Module: int_controller

Interface
REQ-001 SHALL have parameter CHANNELS, default 8, number of interrupt lines; legal range 1..32.
REQ-002 SHALL have parameter ID_W, default 8, width of int_id; CHANNELS SHALL NOT exceed 2^ID_W.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, synchroniser depth per line; legal range 2..3.
REQ-004 SHALL have one clock and an asynchronous, active-low reset.
REQ-005 clk  input  1  sole clock; all state changes on the rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 irq_in  input  CHANNELS  raw asynchronous interrupt lines, rising-edge sensitive.
REQ-008 int_req  output  1  interrupt request to the CPU program counter logic.
REQ-009 int_id  output  ID_W  index of the requested channel, zero-extended.
REQ-010 int_ack  input  1  single-cycle pulse from the CPU: vector jump taken.
REQ-011 reti  input  1  single-cycle pulse from the CPU: return from interrupt executed.
REQ-012 pending  output  CHANNELS  latched, unserviced edge per channel.
REQ-013 mask_we  input  1  mask write strobe (INT_MASK_EN only).
REQ-014 mask_d  input  CHANNELS  new mask value (INT_MASK_EN only).
REQ-015 mask_q  output  CHANNELS  current mask, 1 = enabled (INT_MASK_EN only).

Function
REQ-016 SHALL pass each irq_in bit through SYNC_STAGES flops, then compare it with a registered previous value; synced=1 with prev=0 is an edge.
REQ-017 SHALL set pending[i] on the rising edge SYNC_STAGES cycles after irq_in[i] is first sampled high; a level held high produces exactly one edge.
REQ-018 SHALL implement a FSM with states IDLE, REQ and SERVICE.
REQ-019 IDLE: when (pending & enable) != 0, on the next edge latch the lowest set index into int_id and go to REQ; otherwise stay.
REQ-020 REQ: int_req SHALL be 1, and int_id SHALL stay stable until int_ack.
REQ-021 REQ plus int_ack: on the same edge clear pending[int_id], go to SERVICE, and drop int_req.
REQ-022 SERVICE: int_req SHALL be 0; on reti go to IDLE; int_id SHALL hold its last value.
REQ-023 SHALL ignore int_ack outside REQ and reti outside SERVICE.
REQ-024 Simultaneous new edge and ack-clear on the same channel: set SHALL win, so pending stays 1.
REQ-025 SHALL keep latching edges in all states; priority SHALL be fixed, lowest index highest, with no preemption and no nesting.
REQ-026 int_req SHALL rise no earlier than one cycle after the pending bit is visible: irq sample edge t0 -> int_req high after edge t0+SYNC_STAGES+1.
REQ-027 A channel disabled while in REQ SHALL NOT withdraw the request already issued.

Reset
REQ-028 On reset low: state = IDLE; int_req=0; int_id=0; pending=0; synchroniser and prev flops = 0; mask_q = all ones.
REQ-029 Reset mid-REQ or mid-SERVICE SHALL abort immediately, with no ack or reti required.
REQ-030 A line high across reset release SHALL register as one edge after SYNC_STAGES cycles.

Configuration
REQ-031 Macro INT_MASK_EN defined: mask register present, written from mask_d on the edge where mask_we=1; enable = mask_q; masked channels still set pending.
REQ-032 Macro INT_MASK_EN undefined: ports mask_we, mask_d and mask_q SHALL be absent, and enable = all ones.

Verification
REQ-033 CHANNELS=8: pulse irq_in[5] for 1 cycle at t0 -> pending=0x20 after t0+2; int_req=1 and int_id=5 after t0+3; int_ack -> pending=0x00, int_req=0.
REQ-034 irq_in[6] and irq_in[2] rise in the same cycle -> int_id=2 first; after ack and reti -> int_id=6.
REQ-035 irq_in[0] rises again in the same cycle int_ack clears channel 0 -> pending[0]=1; a second request for 0 follows reti.
REQ-036 INT_MASK_EN, mask=0xFE, irq_in[0] edge -> pending=0x01 and int_req stays 0; write mask=0xFF -> int_req=1 with int_id=0 two cycles later.
REQ-037 reset low while in SERVICE with pending=0x0C -> all outputs 0 within the reset; irq_in held at 0x04 through release -> pending=0x04 after SYNC_STAGES cycles.
REQ-038 Spurious reti in IDLE and int_ack in SERVICE -> no state, pending or output change.

Source files
------------

// File: rtl/int_controller.sv
// -----------------------------------------------------------------------------
// int_controller
//
// Edge-triggered interrupt controller with fixed priority. The lowest index
// has the highest priority. There is no preemption and no nesting.
//
// Each raw irq_in line passes through a SYNC_STAGES-deep synchroniser. A
// rising edge is detected against a registered copy of the synchronised
// value and latched into pending[]. A three-state FSM (IDLE / REQ / SERVICE)
// sequences one interrupt at a time:
//   IDLE    -> REQ     : the lowest enabled pending index is latched into int_id.
//   REQ     -> SERVICE : int_ack clears pending[int_id].
//   SERVICE -> IDLE    : reti returns the FSM to IDLE.
//
// Optional feature: define INT_MASK_EN to add a writable enable mask. This
// adds the ports mask_we, mask_d and mask_q. Masked channels still latch
// edges into pending[]; they are only excluded from selection. Without the
// macro, every channel is enabled.
//
// Ports:
//   clk      in   sole clock, rising edge
//   reset    in   asynchronous reset, active LOW
//   irq_in   in   [CHANNELS] raw asynchronous interrupt lines
//   int_req  out  request to the CPU; high only in REQ
//   int_id   out  [ID_W] index of the requested channel, zero-extended
//   int_ack  in   CPU pulse: vector taken (honoured only in REQ)
//   reti     in   CPU pulse: return from interrupt (honoured only in SERVICE)
//   pending  out  [CHANNELS] latched, unserviced edges
//   mask_we  in   mask write strobe                   (INT_MASK_EN only)
//   mask_d   in   [CHANNELS] new mask value           (INT_MASK_EN only)
//   mask_q   out  [CHANNELS] current mask, 1 = enabled (INT_MASK_EN only)
// -----------------------------------------------------------------------------
module int_controller #(
  parameter int CHANNELS    = 8,
  parameter int ID_W        = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] irq_in,
  output logic                int_req,
  output logic [ID_W-1:0]     int_id,
  input  logic                int_ack,
  input  logic                reti,
  output logic [CHANNELS-1:0] pending
`ifdef INT_MASK_EN
  ,
  input  logic                mask_we,
  input  logic [CHANNELS-1:0] mask_d,
  output logic [CHANNELS-1:0] mask_q
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] prev_q;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] enable;
  logic [CHANNELS-1:0] cand;
  logic [CHANNELS-1:0] clr_vec;
  logic [ID_W-1:0]     first_id;
  logic                any_req;
  logic                id_load;
  logic                ack_take;

  // ---------------------------------------------------------------------------
  // Synchroniser and edge detector. The synchroniser is a handful of flops,
  // not a memory. It is reset so that a line held high across reset release
  // is seen as exactly one fresh edge.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so that every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= irq_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

  // ---------------------------------------------------------------------------
  // Enable mask
  // ---------------------------------------------------------------------------
`ifdef INT_MASK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       mask_q <= '1;
    else if (mask_we) mask_q <= mask_d;
  end
  assign enable = mask_q;
`else
  assign enable = '1;
`endif

  // ---------------------------------------------------------------------------
  // Fixed-priority selection. The loop walks downward so that the lowest set
  // index is the last one assigned, and therefore the one that wins.
  // ---------------------------------------------------------------------------
  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    cand     = pending & enable;
    any_req  = |cand;
    first_id = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (cand[i]) first_id = ID_W'(i);
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register / next-state logic / output logic
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req) state_d = REQ;
      REQ:     if (int_ack) state_d = SERVICE;
      SERVICE: if (reti)    state_d = IDLE;
      default:              state_d = IDLE;
    endcase
  end

  always_comb begin
    int_req  = (state_q == REQ);
    id_load  = (state_q == IDLE) && any_req;
    ack_take = (state_q == REQ) && int_ack;
  end

  // ---------------------------------------------------------------------------
  // Datapath: int_id and pending
  // ---------------------------------------------------------------------------
  // int_id changes only when a new request is issued. It therefore stays
  // stable through REQ and SERVICE, even if the channel is masked meanwhile.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       int_id <= '0;
    else if (id_load) int_id <= first_id;
  end

  always_comb begin
    clr_vec = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      clr_vec[i] = ack_take && (int_id == ID_W'(i));
    end
  end

  // The set term is OR-ed in after the clear, so a new edge that arrives on
  // the acknowledged channel in the same cycle is not lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pending <= '0;
    else        pending <= (pending & ~clr_vec) | rise;
  end

endmodule

// File: tb/tb_int_controller.sv
// -----------------------------------------------------------------------------
// tb_int_controller
//
// Directed scenarios followed by a randomized phase. The testbench keeps a
// behavioural reference model:
//   - Edges are derived from a short history of irq_in samples: a channel
//     becomes pending SYNC_STAGES edges after a 0->1 sample pair.
//   - Servicing is modelled as idle / requesting / serving, with
//     lowest-set-bit arithmetic used for priority.
// Build with +define+INT_MASK_EN to exercise the mask port.
// -----------------------------------------------------------------------------
module tb_int_controller;

  localparam int CH = 8;
  localparam int IW = 8;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [CH-1:0] irq_in;
  logic          int_req;
  logic [IW-1:0] int_id;
  logic          int_ack;
  logic          reti;
  logic [CH-1:0] pending;
`ifdef INT_MASK_EN
  logic          mask_we;
  logic [CH-1:0] mask_d;
  logic [CH-1:0] mask_q;
`endif

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [CH-1:0] hist [$];
  int            m_state;   // 0 idle, 1 requesting, 2 serving
  int            m_id;
  logic [CH-1:0] m_pend;
  logic [CH-1:0] m_mask;

  int_controller #(.CHANNELS(CH), .ID_W(IW), .SYNC_STAGES(SS)) dut (
    .clk     (clk),
    .reset   (reset),
    .irq_in  (irq_in),
    .int_req (int_req),
    .int_id  (int_id),
    .int_ack (int_ack),
    .reti    (reti),
    .pending (pending)
`ifdef INT_MASK_EN
    ,
    .mask_we (mask_we),
    .mask_d  (mask_d),
    .mask_q  (mask_q)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int lowest(input logic [31:0] x);
    return $clog2(x & (~x + 32'd1));
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int k = 0; k <= SS; k++) hist.push_back('0);
    m_state = 0;
    m_id    = 0;
    m_pend  = '0;
    m_mask  = '1;
  endtask

  // One clock: inputs are already set; update the model at the rising edge,
  // then compare all outputs at the falling edge.
  task automatic tick();
    logic [CH-1:0] rises;
    logic [CH-1:0] clr;
    logic [CH-1:0] avail;
    @(posedge clk);
    // hist[1] is the sample from SS edges ago; hist[0] is the one before it.
    rises = hist[1] & ~hist[0];
    void'(hist.pop_front());
    hist.push_back(irq_in);
    clr = '0;
    case (m_state)
      0: begin
        avail = m_pend & m_mask;
        if (avail != '0) begin
          m_id    = lowest(32'(avail));
          m_state = 1;
        end
      end
      1: if (int_ack) begin
        clr     = CH'(1) << m_id;
        m_state = 2;
      end
      default: if (reti) m_state = 0;
    endcase
    m_pend = (m_pend & ~clr) | rises;
`ifdef INT_MASK_EN
    if (mask_we) m_mask = mask_d;
`endif
    @(negedge clk);
    check("model_int_req", 64'(int_req), 64'(m_state == 1));
    check("model_int_id",  64'(int_id),  64'(m_id));
    check("model_pending", 64'(pending), 64'(m_pend));
`ifdef INT_MASK_EN
    check("model_mask_q",  64'(mask_q),  64'(m_mask));
`endif
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    reset   = 1'b0;
    irq_in  = '0;
    int_ack = 1'b0;
    reti    = 1'b0;
`ifdef INT_MASK_EN
    mask_we = 1'b0;
    mask_d  = '0;
`endif
    model_reset();

    // ---- reset state ----
    #2;
    check("rst_int_req", 64'(int_req), 64'd0);
    check("rst_int_id",  64'(int_id),  64'd0);
    check("rst_pending", 64'(pending), 64'd0);
`ifdef INT_MASK_EN
    check("rst_mask_q",  64'(mask_q),  64'hFF);
`endif
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    ticks(2);

    // ---- one-cycle pulse on channel 5 ----
    irq_in = 8'h20; tick();
    irq_in = 8'h00; tick();
    check("p5_pend_t0p1", 64'(pending), 64'h00);
    tick();
    check("p5_pend_t0p2", 64'(pending), 64'h20);
    check("p5_req_t0p2",  64'(int_req), 64'd0);
    tick();
    check("p5_req_t0p3",  64'(int_req), 64'd1);
    check("p5_id_t0p3",   64'(int_id),  64'd5);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    check("p5_ack_pend",  64'(pending), 64'h00);
    check("p5_ack_req",   64'(int_req), 64'd0);
    reti = 1'b1; tick(); reti = 1'b0;

    // ---- channels 6 and 2 together; held high afterwards ----
    irq_in = 8'h44; ticks(4);
    check("pri_first_id",  64'(int_id),  64'd2);
    check("pri_first_req", 64'(int_req), 64'd1);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    reti = 1'b1; tick(); reti = 1'b0;
    tick();
    check("pri_second_id",  64'(int_id),  64'd6);
    check("pri_second_req", 64'(int_req), 64'd1);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    reti = 1'b1; tick(); reti = 1'b0;
    irq_in = 8'h00; ticks(3);

    // ---- spurious reti in IDLE ----
    reti = 1'b1; tick(); reti = 1'b0;
    check("spur_reti_req",  64'(int_req), 64'd0);
    check("spur_reti_pend", 64'(pending), 64'h00);
    check("spur_reti_id",   64'(int_id),  64'd6);

    // ---- new edge on channel 0 in the same cycle as the ack clears it ----
    irq_in = 8'h01; tick();
    irq_in = 8'h00; tick();
    irq_in = 8'h01; tick();
    irq_in = 8'h00; tick();
    check("setwin_req_id", 64'(int_id), 64'd0);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    check("setwin_pend", 64'(pending), 64'h01);
    check("setwin_req",  64'(int_req), 64'd0);
    int_ack = 1'b1; tick(); int_ack = 1'b0;        // spurious ack in SERVICE
    check("spur_ack_req",  64'(int_req), 64'd0);
    check("spur_ack_pend", 64'(pending), 64'h01);
    reti = 1'b1; tick(); reti = 1'b0;
    tick();
    check("setwin_rereq", 64'(int_req), 64'd1);
    check("setwin_reid",  64'(int_id),  64'd0);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    reti = 1'b1; tick(); reti = 1'b0;

`ifdef INT_MASK_EN
    // ---- masked channel still pends; unmasking releases the request ----
    mask_we = 1'b1; mask_d = 8'hFE; tick(); mask_we = 1'b0;
    irq_in = 8'h01; tick();
    irq_in = 8'h00; ticks(4);
    check("mask_pend", 64'(pending), 64'h01);
    check("mask_req",  64'(int_req), 64'd0);
    mask_we = 1'b1; mask_d = 8'hFF; tick(); mask_we = 1'b0;
    tick();
    check("unmask_req", 64'(int_req), 64'd1);
    check("unmask_id",  64'(int_id),  64'd0);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    reti = 1'b1; tick(); reti = 1'b0;
`endif

    // ---- reset while in SERVICE with pending = 0x0C ----
    irq_in = 8'h01; tick();
    irq_in = 8'h00; ticks(3);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    irq_in = 8'h0C; tick();
    irq_in = 8'h00; ticks(2);
    check("pre_rst_pend", 64'(pending), 64'h0C);
    check("pre_rst_req",  64'(int_req), 64'd0);
    irq_in = 8'h04;
    #2 reset = 1'b0;
    #1;
    check("mid_rst_req",  64'(int_req), 64'd0);
    check("mid_rst_id",   64'(int_id),  64'd0);
    check("mid_rst_pend", 64'(pending), 64'h00);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    ticks(2);
    check("post_rst_pend_early", 64'(pending), 64'h00);
    tick();
    check("post_rst_pend", 64'(pending), 64'h04);
    tick();
    check("post_rst_id", 64'(int_id), 64'd2);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    reti = 1'b1; tick(); reti = 1'b0;
    irq_in = 8'h00; ticks(2);

    // ---- randomized phase ----
    for (int n = 0; n < 600; n++) begin
      irq_in  = irq_in ^ (CH'($urandom) & CH'($urandom) & CH'($urandom));
      int_ack = ($urandom_range(0, 2) == 0);
      reti    = ($urandom_range(0, 3) == 0);
`ifdef INT_MASK_EN
      mask_we = ($urandom_range(0, 15) == 0);
      mask_d  = CH'($urandom);
`endif
      tick();
    end
    int_ack = 1'b0;
    reti    = 1'b0;
`ifdef INT_MASK_EN
    mask_we = 1'b0;
`endif
    ticks(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
